// File: rtl/fuel_pkg.sv
// Shared types and constants for the fuel pump controller.
package fuel_pkg;

  localparam int DIST_W = 21;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_PUMP  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'd0,
    FLT_TIMEOUT  = 2'd1,
    FLT_WDOG     = 2'd2,
    FLT_OVERFILL = 2'd3
  } fault_e;

endpackage

// File: rtl/fuel_pump_ctrl_if.sv
// Measurement bus from the ultrasonic ranging block.
interface fuel_pump_ctrl_if;
  import fuel_pkg::*;

  logic              new_measure;
  logic              timeout;
  logic [DIST_W-1:0] distance_raw;

  modport master (output new_measure, timeout, distance_raw);
  modport slave  (input  new_measure, timeout, distance_raw);
endinterface

// File: rtl/fuel_pump_ctrl_dist_avg.sv
// Box-car averager over 2^AVG_LOG2 valid samples plus a saturating
// consecutive-timeout counter.
module dist_avg
  import fuel_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int MAX_TO   = 3,
  parameter int TO_W     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              new_measure,
  input  logic              timeout,
  input  logic [DIST_W-1:0] distance_raw,
  input  logic              clear,
  output logic [DIST_W-1:0] avg,
  output logic              avg_valid,
  output logic [TO_W-1:0]   timeout_cnt
);
  localparam int ACC_W = DIST_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(MAX_TO);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

  logic [ACC_W-1:0]  acc_q, acc_d, sum;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [DIST_W-1:0] avg_q, avg_d;
  logic              avg_valid_q, avg_valid_d;

  // accumulate valid samples, emit truncated mean on the last one
  always_comb begin
    sum         = acc_q + ACC_W'(distance_raw);
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    to_cnt_d    = to_cnt_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    if (clear) begin
      acc_d    = '0;
      cnt_d    = '0;
      to_cnt_d = '0;
    end else if (new_measure) begin
      if (!timeout) begin
        to_cnt_d = '0;
        if (cnt_q == CNT_LAST) begin
          avg_d       = DIST_W'(sum >> AVG_LOG2);
          avg_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
        end else begin
          acc_d = sum;
          cnt_d = cnt_q + CNT_ONE;
        end
      end else if (to_cnt_q != TO_MAX) begin
        to_cnt_d = to_cnt_q + TO_ONE;
      end
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      to_cnt_q    <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      to_cnt_q    <= to_cnt_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  assign avg         = avg_q;
  assign avg_valid   = avg_valid_q;
  assign timeout_cnt = to_cnt_q;

endmodule

// File: rtl/fuel_pump_ctrl.sv
// Hysteresis fill controller with sensor-loss, watchdog and overfill faults.
// Optional anti-short-cycle hold-off enabled by FUEL_PUMP_MIN_OFF_EN.
module fuel_pump_ctrl
  import fuel_pkg::*;
#(
  parameter int AVG_LOG2        = 2,
  parameter int LOW_DIST        = 30000,
  parameter int FULL_DIST       = 10000,
  parameter int MIN_DIST        = 2500,
  parameter int MAX_TIMEOUTS    = 3,
  parameter int MAX_PUMP_CYCLES = 1500000000
`ifdef FUEL_PUMP_MIN_OFF_EN
  ,
  parameter int MIN_OFF_CYCLES  = 250000000
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    clr_fault,
  fuel_pump_ctrl_if.slave         meas,
  output logic                    pump_on,
  output logic                    avg_valid,
  output logic [DIST_W-1:0]       avg_distance,
  output logic [1:0]              state,
  output logic [1:0]              fault_code
);
  localparam int TO_W = $clog2(MAX_TIMEOUTS + 1);
  localparam logic [DIST_W-1:0] LOW_D     = DIST_W'(LOW_DIST);
  localparam logic [DIST_W-1:0] FULL_D    = DIST_W'(FULL_DIST);
  localparam logic [DIST_W-1:0] MIN_D     = DIST_W'(MIN_DIST);
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(MAX_TIMEOUTS);
  localparam logic [31:0]       WDOG_LAST = 32'(MAX_PUMP_CYCLES - 1);

  state_e      state_q, state_d;
  fault_e      fault_q, fault_d;
  logic [31:0] wdog_q, wdog_d;
  logic        pump_on_q, pump_on_d;
  logic        holdoff_ok;

  logic [DIST_W-1:0] avg;
  logic              avg_vld;
  logic [TO_W-1:0]   to_cnt;
  logic              meas_en, avg_clear;

  // samples only count while running; OFF (or about to be) wipes the average
  assign meas_en   = meas.new_measure && (state_q == ST_IDLE || state_q == ST_PUMP);
  assign avg_clear = (state_q == ST_OFF) || (state_d == ST_OFF);

  dist_avg #(.AVG_LOG2(AVG_LOG2), .MAX_TO(MAX_TIMEOUTS), .TO_W(TO_W)) u_avg (
    .clk          (clk),
    .rst_n        (rst_n),
    .new_measure  (meas_en),
    .timeout      (meas.timeout),
    .distance_raw (meas.distance_raw),
    .clear        (avg_clear),
    .avg          (avg),
    .avg_valid    (avg_vld),
    .timeout_cnt  (to_cnt)
  );

`ifdef FUEL_PUMP_MIN_OFF_EN
  logic [31:0] holdoff_q, holdoff_d;
  assign holdoff_ok = (holdoff_q == '0);

  // hold-off loads on stop, counts down, and is cleared outside IDLE/PUMP
  always_comb begin
    holdoff_d = holdoff_q;
    if (state_d == ST_OFF || state_d == ST_FAULT)
      holdoff_d = '0;
    else if (state_q == ST_PUMP && state_d == ST_IDLE)
      holdoff_d = 32'(MIN_OFF_CYCLES);
    else if (holdoff_q != '0)
      holdoff_d = holdoff_q - 32'd1;
  end

  // hold-off register
  always_ff @(posedge clk) begin
    if (!rst_n) holdoff_q <= '0;
    else        holdoff_q <= holdoff_d;
  end
`else
  assign holdoff_ok = 1'b1;
`endif

  // next state: faults, then enable drop, then fill hysteresis
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      ST_OFF: if (enable) state_d = ST_IDLE;
      ST_IDLE, ST_PUMP: begin
        if (to_cnt >= TO_LIMIT) begin
          state_d = ST_FAULT;
          fault_d = FLT_TIMEOUT;
        end else if (avg_vld && avg < MIN_D) begin
          state_d = ST_FAULT;
          fault_d = FLT_OVERFILL;
        end else if (state_q == ST_PUMP && wdog_q >= WDOG_LAST) begin
          state_d = ST_FAULT;
          fault_d = FLT_WDOG;
        end else if (!enable) begin
          state_d = ST_OFF;
        end else if (state_q == ST_IDLE) begin
          if (avg_vld && avg >= LOW_D && holdoff_ok) state_d = ST_PUMP;
        end else begin
          if (avg_vld && avg <= FULL_D) state_d = ST_IDLE;
        end
      end
      default: if (clr_fault) begin
        state_d = ST_OFF;
        fault_d = FLT_NONE;
      end
    endcase
    wdog_d    = (state_q == ST_PUMP && state_d == ST_PUMP) ? wdog_q + 32'd1 : '0;
    pump_on_d = (state_d == ST_PUMP);
  end

  // FSM, watchdog and pump drive registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      fault_q   <= FLT_NONE;
      wdog_q    <= '0;
      pump_on_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      wdog_q    <= wdog_d;
      pump_on_q <= pump_on_d;
    end
  end

  assign pump_on      = pump_on_q;
  assign avg_valid    = avg_vld;
  assign avg_distance = avg;
  assign state        = state_q;
  assign fault_code   = fault_q;

endmodule

// File: tb/tb_fuel_pump_ctrl.sv
// Directed-vector bench for fuel_pump_ctrl (watchdog shortened to 1000 cycles).
module tb_fuel_pump_ctrl;
  import fuel_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n, enable, clr_fault;
  logic              pump_on, avg_valid;
  logic [DIST_W-1:0] avg_distance;
  logic [1:0]        state, fault_code;
  int                total = 0;
  int                bad   = 0;

  fuel_pump_ctrl_if mif();

  fuel_pump_ctrl #(
    .MAX_PUMP_CYCLES (1000)
`ifdef FUEL_PUMP_MIN_OFF_EN
    ,
    .MIN_OFF_CYCLES  (500)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .clr_fault    (clr_fault),
    .meas         (mif),
    .pump_on      (pump_on),
    .avg_valid    (avg_valid),
    .avg_distance (avg_distance),
    .state        (state),
    .fault_code   (fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // one-cycle measurement pulse; returns #1 after the sampling edge
  task automatic send(input logic [DIST_W-1:0] d, input logic to);
    mif.new_measure  = 1'b1;
    mif.timeout      = to;
    mif.distance_raw = d;
    @(posedge clk); #1;
    mif.new_measure  = 1'b0;
    mif.timeout      = 1'b0;
  endtask

  task automatic feed4(input int d, input bit exp_v);
    logic [DIST_W-1:0] dv;
    dv = d[DIST_W-1:0];
    for (int i = 0; i < 4; i++) begin
      if (i != 0) idle(2);
      send(dv, 1'b0);
      chk($sformatf("vld_%0d_%0d", d, i), {31'd0, avg_valid}, (i == 3) ? {31'd0, exp_v} : 32'd0);
    end
  endtask

  task automatic clear_fault();
    clr_fault = 1'b1;
    idle(1);
    chk("clr_state", state, 0);
    chk("clr_code", fault_code, 0);
    clr_fault = 1'b0;
    idle(1);
    chk("clr_idle", state, 1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clr_fault = 1'b0;
    mif.new_measure = 1'b0; mif.timeout = 1'b0; mif.distance_raw = '0;
    idle(3);
    chk("rst_pump", pump_on, 0);
    chk("rst_vld", avg_valid, 0);
    chk("rst_avg", avg_distance, 0);
    chk("rst_state", state, 0);
    chk("rst_code", fault_code, 0);
    rst_n = 1'b1;
    idle(1);
    chk("off_hold", state, 0);

    // fill cycle
    enable = 1'b1;
    idle(1);
    chk("en_idle", state, 1);
    feed4(35000, 1);
    chk("fill_avg", avg_distance, 35000);
    chk("fill_t1_state", state, 1);
    chk("fill_t1_pump", pump_on, 0);
    idle(1);
    chk("fill_state", state, 2);
    chk("fill_pump", pump_on, 1);
    chk("fill_vld_low", avg_valid, 0);

    // hysteresis while pumping
    idle(2); feed4(20000, 1); idle(1);
    chk("hyst_pump_avg", avg_distance, 20000);
    chk("hyst_pump", state, 2);

    // full -> stop
    idle(2); feed4(8000, 1); idle(1);
    chk("full_state", state, 1);
    chk("full_pump", pump_on, 0);

    // hysteresis while idle
    idle(2); feed4(20000, 1); idle(1);
    chk("hyst_idle", state, 1);

    // truncating average: 40007 >> 2 = 10001
    idle(2); send(21'd10001, 1'b0);
    idle(2); send(21'd10002, 1'b0);
    idle(2); send(21'd10002, 1'b0);
    idle(2); send(21'd10002, 1'b0);
    chk("trunc_vld", avg_valid, 1);
    chk("trunc_avg", avg_distance, 10001);
    idle(1);
    chk("trunc_state", state, 1);

    // partial average discarded by one-cycle disable
    idle(2); send(21'd40000, 1'b0);
    idle(2); send(21'd40000, 1'b0);
    enable = 1'b0;
    idle(1);
    chk("dis_off", state, 0);
    enable = 1'b1;
    idle(1);
    chk("dis_idle", state, 1);
    feed4(40000, 1);
    chk("dis_avg", avg_distance, 40000);
    idle(1);
    chk("dis_pump", state, 2);

    // sensor loss in PUMP
    idle(2); send('0, 1'b1);
    idle(2); send('0, 1'b1);
    idle(2); send('0, 1'b1);
    chk("to_t1_state", state, 2);
    idle(1);
    chk("to_state", state, 3);
    chk("to_code", fault_code, 1);
    chk("to_pump", pump_on, 0);
    idle(2); feed4(2000, 0); idle(1);
    chk("flt_frozen_avg", avg_distance, 40000);
    chk("flt_hold", state, 3);
    chk("flt_code_hold", fault_code, 1);
    clear_fault();

    // overfill in IDLE
    idle(2); feed4(2000, 1);
    chk("of_avg", avg_distance, 2000);
    idle(1);
    chk("of_state", state, 3);
    chk("of_code", fault_code, 3);
    clear_fault();

    // pump watchdog: no samples after entering PUMP
    idle(2); feed4(35000, 1); idle(1);
    chk("wd_enter", state, 2);
    idle(999);
    chk("wd_999", state, 2);
    idle(1);
    chk("wd_state", state, 3);
    chk("wd_code", fault_code, 2);
    chk("wd_pump", pump_on, 0);
    clear_fault();

`ifdef FUEL_PUMP_MIN_OFF_EN
    // anti-short-cycle hold-off
    idle(2); feed4(35000, 1); idle(1);
    chk("ho_pump", state, 2);
    idle(2); feed4(8000, 1); idle(1);
    chk("ho_stop", state, 1);
    idle(2); feed4(35000, 1); idle(1);
    chk("ho_blocked", state, 1);
    idle(500);
    feed4(35000, 1); idle(1);
    chk("ho_released", state, 2);
    chk("ho_pump_on", pump_on, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
